// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg: shared FSM state and requester encodings for the pmem arbiter.
package arb_types;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} arb_state_t;
  typedef enum logic {REQ_I, REQ_D} arb_req_t;
endpackage

// File: rtl/cache_mem_arbiter_arb_pick.sv
// arb_pick: combinational winner select between I-cache and D-cache requests.
// ARB_RR_EN selects round-robin on conflicts; otherwise D has fixed priority.
module arb_pick
  import arb_types::*;
(
  input  logic     i_req,
  input  logic     d_req,
  input  arb_req_t last_grant,
  output arb_req_t grant
);
`ifdef ARB_RR_EN
  assign grant = (i_req && d_req) ? ((last_grant == REQ_I) ? REQ_D : REQ_I)
                                  : (d_req ? REQ_D : REQ_I);
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant = d_req ? REQ_D : REQ_I;
`endif
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: serialises I-cache and D-cache line transactions onto one pmem port.
// Conflict policy set by ARB_RR_EN (round-robin) or its absence (D-cache priority).
module cache_mem_arbiter
  import arb_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  arb_state_t        state_q, state_d;
  arb_req_t          last_grant_q, last_grant_d, win;
  logic              wr_q, wr_d, d_req, serve;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  assign d_req = d_mem_read || d_mem_write;
  arb_pick u_pick (.i_req(i_mem_read), .d_req(d_req), .last_grant(last_grant_q), .grant(win));
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_mem_resp   = 1'b0;
    d_mem_resp   = 1'b0;
    case (state_q)
      IDLE: if (i_mem_read || d_req) begin
        state_d = (win == REQ_D) ? SERVE_D : SERVE_I;
        addr_d  = (win == REQ_D) ? d_mem_address : i_mem_address;
        wr_d    = (win == REQ_D) && d_mem_write;
        wdata_d = (win == REQ_D) ? d_mem_wdata : wdata_q;
      end
      SERVE_I: if (pmem_resp) begin
        i_mem_resp   = 1'b1;
        i_rdata_d    = pmem_rdata;
        last_grant_d = REQ_I;
        state_d      = DONE;
      end
      SERVE_D: if (pmem_resp) begin
        d_mem_resp   = 1'b1;
        d_rdata_d    = pmem_rdata;
        last_grant_d = REQ_D;
        state_d      = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Response data bypasses the holding register so it arrives with the resp pulse.
  assign serve        = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign pmem_read    = serve && !wr_q;
  assign pmem_write   = serve && wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_mem_rdata  = i_mem_resp ? pmem_rdata : i_rdata_q;
  assign d_mem_rdata  = d_mem_resp ? pmem_rdata : d_rdata_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_I;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: randomized self-checking bench with a transaction-level arbitration model.
module tb_cache_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  logic          clk = 1'b0, rst = 1'b1;
  logic          i_mem_read = 1'b0, i_mem_resp;
  logic [AW-1:0] i_mem_address = '0;
  logic [LW-1:0] i_mem_rdata;
  logic          d_mem_read = 1'b0, d_mem_write = 1'b0, d_mem_resp;
  logic [AW-1:0] d_mem_address = '0;
  logic [LW-1:0] d_mem_wdata = '0, d_mem_rdata;
  logic          pmem_read, pmem_write, pmem_resp = 1'b0;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata, pmem_rdata = '0;
  logic [3*LW+AW+3:0] all_out;
  int  n_cmp = 0, n_bad = 0;
  bit  model_lg = 1'b0;
  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address), .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_address(d_mem_address),
    .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );
  assign all_out = {i_mem_rdata, i_mem_resp, d_mem_rdata, d_mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata};
  always #5 clk = ~clk;
  function automatic bit pick_d(bit i, bit d);
    if (i && d) begin
`ifdef ARB_RR_EN
      return !model_lg;
`else
      return 1'b1;
`endif
    end
    return d;
  endfunction
  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic do_serve(input logic [LW-1:0] rd, input int delay, input bit drop_i, input bit drop_d, input bit chg_wd,
                          output int lat, output logic [AW-1:0] o_addr, output bit o_rd, output bit o_wr,
                          output logic [LW-1:0] o_wd, output logic [LW-1:0] o_wd_late,
                          output bit o_ir, output bit o_dr, output logic [LW-1:0] o_ird, output logic [LW-1:0] o_drd);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(pmem_read || pmem_write) && lat < 20);
    o_addr = pmem_address; o_rd = pmem_read; o_wr = pmem_write; o_wd = pmem_wdata;
    for (int k = 0; k < delay; k++) begin
      if (drop_i) i_mem_read = 1'b0;
      if (drop_d) begin d_mem_read = 1'b0; d_mem_write = 1'b0; end
      if (chg_wd) d_mem_wdata = d_mem_wdata + 1'b1;
      tick();
    end
    o_wd_late = pmem_wdata;
    pmem_rdata = rd;
    pmem_resp = 1'b1;
    #1;
    o_ir = i_mem_resp; o_dr = d_mem_resp; o_ird = i_mem_rdata; o_drd = d_mem_rdata;
    tick();
    pmem_resp = 1'b0;
    pmem_rdata = rnd_line();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    @(negedge clk) rst = 1'b1;
    tick();
    n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL post_reset_outputs got=%h exp=0", all_out); end
    model_lg = 1'b0;
  endtask
  task automatic test_lone_i();
    int lat; logic [AW-1:0] a; bit r, w, ir, dr; logic [LW-1:0] wd, wdl, ird, drd, rd;
    rd = {32{8'hAA}};
    i_mem_read = 1'b1; i_mem_address = 32'h0000_1000;
    do_serve(rd, $urandom_range(0, 2), 0, 0, 0, lat, a, r, w, wd, wdl, ir, dr, ird, drd);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL lone_i_latency got=%0d exp=1", lat); end
    n_cmp++; if (a !== 32'h1000) begin n_bad++; $display("FAIL lone_i_addr got=%h exp=00001000", a); end
    n_cmp++; if ({r, w} !== 2'b10) begin n_bad++; $display("FAIL lone_i_op got=%b exp=10", {r, w}); end
    n_cmp++; if ({ir, dr} !== 2'b10) begin n_bad++; $display("FAIL lone_i_resp got=%b exp=10", {ir, dr}); end
    n_cmp++; if (ird !== rd) begin n_bad++; $display("FAIL lone_i_rdata got=%h exp=%h", ird, rd); end
    model_lg = 1'b0;
    i_mem_read = 1'b0;
    #1;
    n_cmp++; if ({i_mem_resp, pmem_read} !== 2'b00) begin n_bad++; $display("FAIL done_quiet got=%b exp=00", {i_mem_resp, pmem_read}); end
    n_cmp++; if (i_mem_rdata !== rd) begin n_bad++; $display("FAIL i_rdata_hold got=%h exp=%h", i_mem_rdata, rd); end
    tick();
  endtask
  task automatic test_d_write();
    int lat; logic [AW-1:0] a; bit r, w, ir, dr; logic [LW-1:0] wd, wdl, ird, drd, rd, wexp;
    rd = rnd_line(); wexp = {32{8'h55}};
    d_mem_read = 1'b1; d_mem_write = 1'b1; d_mem_address = 32'h80; d_mem_wdata = wexp;
    do_serve(rd, 2, 0, 0, 1, lat, a, r, w, wd, wdl, ir, dr, ird, drd);
    n_cmp++; if ({r, w} !== 2'b01) begin n_bad++; $display("FAIL dwr_op got=%b exp=01", {r, w}); end
    n_cmp++; if (a !== 32'h80) begin n_bad++; $display("FAIL dwr_addr got=%h exp=00000080", a); end
    n_cmp++; if (wd !== wexp) begin n_bad++; $display("FAIL dwr_wdata got=%h exp=%h", wd, wexp); end
    n_cmp++; if (wdl !== wexp) begin n_bad++; $display("FAIL dwr_wdata_held got=%h exp=%h", wdl, wexp); end
    n_cmp++; if ({ir, dr} !== 2'b01) begin n_bad++; $display("FAIL dwr_resp got=%b exp=01", {ir, dr}); end
    n_cmp++; if (drd !== rd) begin n_bad++; $display("FAIL dwr_rdata got=%h exp=%h", drd, rd); end
    model_lg = 1'b1;
    d_mem_read = 1'b0; d_mem_write = 1'b0;
    tick();
  endtask
  task automatic test_conflict(input int reps);
    int lat; logic [AW-1:0] a, ia, da; bit r, w, ir, dr, exp_d; logic [LW-1:0] wd, wdl, ird, drd, rd;
    for (int n = 0; n < reps; n++) begin
      ia = $urandom & ~32'h1f; da = $urandom & ~32'h1f; rd = rnd_line();
      i_mem_read = 1'b1; i_mem_address = ia; d_mem_read = 1'b1; d_mem_address = da;
      exp_d = pick_d(1'b1, 1'b1);
      do_serve(rd, $urandom_range(0, 2), 0, 0, 0, lat, a, r, w, wd, wdl, ir, dr, ird, drd);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL conf_first_lat got=%0d exp=1", lat); end
      n_cmp++; if (a !== (exp_d ? da : ia)) begin n_bad++; $display("FAIL conf_first_addr got=%h exp=%h", a, exp_d ? da : ia); end
      n_cmp++; if ({ir, dr} !== {!exp_d, exp_d}) begin n_bad++; $display("FAIL conf_first_resp got=%b exp=%b", {ir, dr}, {!exp_d, exp_d}); end
      model_lg = exp_d;
      if (exp_d) d_mem_read = 1'b0; else i_mem_read = 1'b0;
      rd = rnd_line();
      do_serve(rd, $urandom_range(0, 2), 0, 0, 0, lat, a, r, w, wd, wdl, ir, dr, ird, drd);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL conf_second_lat got=%0d exp=2", lat); end
      n_cmp++; if (a !== (exp_d ? ia : da)) begin n_bad++; $display("FAIL conf_second_addr got=%h exp=%h", a, exp_d ? ia : da); end
      n_cmp++; if ({ir, dr} !== {exp_d, !exp_d}) begin n_bad++; $display("FAIL conf_second_resp got=%b exp=%b", {ir, dr}, {exp_d, !exp_d}); end
      n_cmp++; if ((exp_d ? ird : drd) !== rd) begin n_bad++; $display("FAIL conf_second_rdata got=%h exp=%h", exp_d ? ird : drd, rd); end
      model_lg = !exp_d;
      i_mem_read = 1'b0; d_mem_read = 1'b0;
      tick();
    end
  endtask
  task automatic test_spurious();
    int lat; logic [AW-1:0] a; bit r, w, ir, dr; logic [LW-1:0] wd, wdl, ird, drd;
    pmem_resp = 1'b1; pmem_rdata = rnd_line();
    #1;
    n_cmp++; if ({i_mem_resp, d_mem_resp, pmem_read, pmem_write} !== 4'b0) begin n_bad++; $display("FAIL spur_idle got=%b exp=0000", {i_mem_resp, d_mem_resp, pmem_read, pmem_write}); end
    tick();
    pmem_resp = 1'b0;
    n_cmp++; if ({pmem_read, pmem_write} !== 2'b00) begin n_bad++; $display("FAIL spur_idle_state got=%b exp=00", {pmem_read, pmem_write}); end
    d_mem_read = 1'b1; d_mem_address = 32'h0000_4000;
    do_serve(rnd_line(), 0, 0, 0, 0, lat, a, r, w, wd, wdl, ir, dr, ird, drd);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL spur_idle_lat got=%0d exp=1", lat); end
    model_lg = 1'b1;
    d_mem_read = 1'b0;
    pmem_resp = 1'b1;
    #1;
    n_cmp++; if ({i_mem_resp, d_mem_resp} !== 2'b00) begin n_bad++; $display("FAIL spur_done got=%b exp=00", {i_mem_resp, d_mem_resp}); end
    tick();
    pmem_resp = 1'b0;
    i_mem_read = 1'b1; i_mem_address = 32'h0000_5000;
    do_serve(rnd_line(), 0, 0, 0, 0, lat, a, r, w, wd, wdl, ir, dr, ird, drd);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL spur_done_lat got=%0d exp=1", lat); end
    n_cmp++; if (a !== 32'h5000) begin n_bad++; $display("FAIL spur_done_addr got=%h exp=00005000", a); end
    model_lg = 1'b0;
    i_mem_read = 1'b0;
    tick();
  endtask
  task automatic test_reset_mid();
    d_mem_read = 1'b1; d_mem_address = 32'h0000_2000;
    tick();
    n_cmp++; if (pmem_read !== 1'b1) begin n_bad++; $display("FAIL rmid_pre got=%b exp=1", pmem_read); end
    rst = 1'b0; pmem_resp = 1'b1; pmem_rdata = rnd_line();
    #1;
    n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL rmid_outputs got=%h exp=0", all_out); end
    d_mem_read = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick();
    n_cmp++; if ({i_mem_resp, d_mem_resp, pmem_read, pmem_write} !== 4'b0) begin n_bad++; $display("FAIL rmid_stale got=%b exp=0000", {i_mem_resp, d_mem_resp, pmem_read, pmem_write}); end
    pmem_resp = 1'b0;
    model_lg = 1'b0;
    tick();
  endtask
  task automatic test_random(input int iters);
    int lat; logic [AW-1:0] a, ia, da; bit r, w, ir, dr, ireq, dreq, dwr, exp_d, drop; int dly;
    logic [LW-1:0] wd, wdl, ird, drd, rd, dwd;
    for (int n = 0; n < iters; n++) begin
      ireq = $urandom_range(0, 1); dreq = $urandom_range(0, 1); dwr = $urandom_range(0, 1);
      if (!ireq && !dreq && !dwr) ireq = 1'b1;
      ia = $urandom & ~32'h1f; da = $urandom & ~32'h1f; dwd = rnd_line(); rd = rnd_line();
      i_mem_read = ireq; i_mem_address = ia; d_mem_read = dreq; d_mem_write = dwr; d_mem_address = da; d_mem_wdata = dwd;
      exp_d = pick_d(ireq, dreq || dwr);
      dly = $urandom_range(0, 3); drop = $urandom_range(0, 1);
      do_serve(rd, dly, drop && !exp_d, drop && exp_d, 0, lat, a, r, w, wd, wdl, ir, dr, ird, drd);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL rnd%0d_lat got=%0d exp=1", n, lat); end
      n_cmp++; if (a !== (exp_d ? da : ia)) begin n_bad++; $display("FAIL rnd%0d_addr got=%h exp=%h", n, a, exp_d ? da : ia); end
      n_cmp++; if ({r, w} !== {!(exp_d && dwr), exp_d && dwr}) begin n_bad++; $display("FAIL rnd%0d_op got=%b exp=%b", n, {r, w}, {!(exp_d && dwr), exp_d && dwr}); end
      if (exp_d && dwr) begin
        n_cmp++; if (wd !== dwd) begin n_bad++; $display("FAIL rnd%0d_wdata got=%h exp=%h", n, wd, dwd); end
      end
      n_cmp++; if ({ir, dr} !== {!exp_d, exp_d}) begin n_bad++; $display("FAIL rnd%0d_resp got=%b exp=%b", n, {ir, dr}, {!exp_d, exp_d}); end
      n_cmp++; if ((exp_d ? drd : ird) !== rd) begin n_bad++; $display("FAIL rnd%0d_rdata got=%h exp=%h", n, exp_d ? drd : ird, rd); end
      model_lg = exp_d;
      if (exp_d) begin d_mem_read = 1'b0; d_mem_write = 1'b0; end else i_mem_read = 1'b0;
      if (exp_d ? ireq : (dreq || dwr)) begin
        rd = rnd_line();
        do_serve(rd, $urandom_range(0, 2), 0, 0, 0, lat, a, r, w, wd, wdl, ir, dr, ird, drd);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rnd%0d_second_lat got=%0d exp=2", n, lat); end
        n_cmp++; if (a !== (exp_d ? ia : da)) begin n_bad++; $display("FAIL rnd%0d_second_addr got=%h exp=%h", n, a, exp_d ? ia : da); end
        n_cmp++; if ({ir, dr} !== {exp_d, !exp_d}) begin n_bad++; $display("FAIL rnd%0d_second_resp got=%b exp=%b", n, {ir, dr}, {exp_d, !exp_d}); end
        model_lg = !exp_d;
      end
      i_mem_read = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0;
      tick();
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_lone_i();
    test_d_write();
    test_conflict(3);
    test_spurious();
    test_reset_mid();
    test_random(25);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
